// File: rtl/inter_request_controller_pkg.sv
// Shared types and constants for the interrupt request controller.
// The index-width helper keeps a 1-source build from collapsing to zero width.
package InterCtrl_Pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASK    = 2'd1,
    HANDLE = 2'd2
  } state_t;

  localparam int INTER_CODE_W       = 8;
  localparam int EXCEPTION_CODE_NUM = 16;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/inter_request_controller_encoder.sv
// Fixed-priority encoder: lowest set index wins; purely combinational.
// No handshake: vld is simply the OR of req.
module InterPriority_Encoder #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     req,
  output logic             vld,
  output logic [IDX_W-1:0] idx
);

  // Scanning downwards lets the lowest set bit overwrite any higher one.
  always_comb begin
    vld = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        vld = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/inter_request_controller.sv
// Latches/arbitrates interrupt sources into the core's interAsk/interCode; 1-cycle (level) or 2-cycle (edge) latency.
// The core's askInterHandle/askRestartHandle pace it; INTER_EDGE_TRIG_EN selects edge-latched pending bits.
module inter_request_controller
  import InterCtrl_Pkg::*;
#(
  parameter int SRC_NUM   = 16,
  parameter int CODE_BASE = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SRC_NUM-1:0]      srcReq,
  input  logic [SRC_NUM-1:0]      srcEnable,
  input  logic                    askInterHandle,
  input  logic                    askRestartHandle,
  output logic                    interAsk,
  output logic [INTER_CODE_W-1:0] interCode,
  output logic [SRC_NUM-1:0]      pendingVec,
  output logic                    readyInter,
  output logic                    readyRestart
);

  localparam int IDX_W = idx_width(SRC_NUM);

  if (SRC_NUM < 1 || SRC_NUM > 240 || CODE_BASE < EXCEPTION_CODE_NUM ||
      CODE_BASE + SRC_NUM > 256) begin : g_bad_cfg
    $error("inter_request_controller: SRC_NUM/CODE_BASE out of range");
  end

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic [SRC_NUM-1:0]      pending;
  logic                    win_vld;
  logic [IDX_W-1:0]        win_idx;
  logic                    ask_nxt, ready_inter_nxt, ready_restart_nxt;
  logic                    restart_prev;
  logic [INTER_CODE_W-1:0] code_nxt;

`ifdef INTER_EDGE_TRIG_EN
  logic [SRC_NUM-1:0] src_prev;
  logic [SRC_NUM-1:0] clr_vec;

  always_comb begin
    clr_vec = '0;
    if (state == ASK && askInterHandle && !askRestartHandle) clr_vec[idx] = 1'b1;
  end

  // A fresh edge in the accept cycle survives the clear and is re-requested.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending  <= '0;
      src_prev <= '0;
    end else begin
      src_prev <= srcReq;
      if (askRestartHandle) pending <= '0;
      else                  pending <= (pending & ~clr_vec) | (srcReq & ~src_prev);
    end
  end
`else
  assign pending = srcReq;
`endif

  assign pendingVec = pending;

  InterPriority_Encoder #(
    .N     (SRC_NUM),
    .IDX_W (IDX_W)
  ) u_enc (
    .req (pending & srcEnable),
    .vld (win_vld),
    .idx (win_idx)
  );

  always_comb begin
    state_nxt         = state;
    idx_nxt           = idx;
    ask_nxt           = interAsk;
    code_nxt          = interCode;
    ready_inter_nxt   = readyInter;
    ready_restart_nxt = askRestartHandle & restart_prev;
    if (askRestartHandle) begin
      state_nxt       = IDLE;
      ask_nxt         = 1'b0;
      ready_inter_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            idx_nxt   = win_idx;
            ask_nxt   = 1'b1;
            code_nxt  = INTER_CODE_W'(CODE_BASE) + INTER_CODE_W'(win_idx);
            state_nxt = ASK;
          end
        end
        ASK: begin
          if (askInterHandle) begin
            ask_nxt         = 1'b0;
            ready_inter_nxt = 1'b1;
            state_nxt       = HANDLE;
          end
        end
        HANDLE: begin
          ready_inter_nxt = 1'b1;
          if (!askInterHandle) begin
            ready_inter_nxt = 1'b0;
            state_nxt       = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      idx          <= '0;
      interAsk     <= 1'b0;
      interCode    <= '0;
      readyInter   <= 1'b0;
      readyRestart <= 1'b0;
      restart_prev <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      interAsk     <= ask_nxt;
      interCode    <= code_nxt;
      readyInter   <= ready_inter_nxt;
      readyRestart <= ready_restart_nxt;
      restart_prev <= askRestartHandle;
    end
  end

endmodule

// File: tb/tb_inter_request_controller.sv
// Bench for inter_request_controller: directed stimulus, expected codes queued and checked by a monitor.
// Runs the level-mode sequence by default and the edge-mode sequence when INTER_EDGE_TRIG_EN is defined.
module tb_inter_request_controller;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] srcReq;
  logic [N-1:0] srcEnable;
  logic         askInterHandle;
  logic         askRestartHandle;
  logic         interAsk;
  logic [7:0]   interCode;
  logic [N-1:0] pendingVec;
  logic         readyInter;
  logic         readyRestart;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  inter_request_controller #(
    .SRC_NUM   (N),
    .CODE_BASE (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .srcReq           (srcReq),
    .srcEnable        (srcEnable),
    .askInterHandle   (askInterHandle),
    .askRestartHandle (askRestartHandle),
    .interAsk         (interAsk),
    .interCode        (interCode),
    .pendingVec       (pendingVec),
    .readyInter       (readyInter),
    .readyRestart     (readyRestart)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ask(input string name, input int budget);
    int n = 0;
    while (!interAsk && n < budget) begin
      tick();
      n++;
    end
    check(name, {31'd0, interAsk}, 32'd1);
  endtask

  // Accept the outstanding request, then let the handler return with srcReq = req_after.
  task automatic accept_round(input string name, input logic [N-1:0] req_after);
    askInterHandle = 1'b1;
    tick();
    check({name, "_ask_drop"}, {31'd0, interAsk}, 32'd0);
    check({name, "_ready_inter"}, {31'd0, readyInter}, 32'd1);
    srcReq         = req_after;
    askInterHandle = 1'b0;
    tick();
    check({name, "_ready_inter_clr"}, {31'd0, readyInter}, 32'd0);
  endtask

  // Pops an expected code on every interAsk rise and checks it stays stable and spaced.
  task automatic monitor();
    logic       ask_prev = 1'b0;
    int         low_cnt  = 100;
    logic [7:0] cur_exp  = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        ask_prev = 1'b0;
        low_cnt  = 100;
      end else begin
        if (interAsk && !ask_prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_request", {24'd0, interCode}, 32'd0 - 1);
          end else begin
            cur_exp = exp_q.pop_front();
            check("request_code", {24'd0, interCode}, {24'd0, cur_exp});
          end
          check("min_gap_ok", {31'd0, (low_cnt >= 2)}, 32'd1);
        end else if (interAsk) begin
          check("code_stable", {24'd0, interCode}, {24'd0, cur_exp});
        end
        low_cnt  = interAsk ? 0 : low_cnt + 1;
        ask_prev = interAsk;
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    rst              = 1'b0;
    srcReq           = '0;
    srcEnable        = '1;
    askInterHandle   = 1'b0;
    askRestartHandle = 1'b0;
    repeat (3) tick();
    check("rst_interAsk", {31'd0, interAsk}, 32'd0);
    check("rst_interCode", {24'd0, interCode}, 32'd0);
    check("rst_readyInter", {31'd0, readyInter}, 32'd0);
    check("rst_readyRestart", {31'd0, readyRestart}, 32'd0);
    check("rst_pending", {16'd0, pendingVec}, 32'd0);
    rst = 1'b1;
    tick();

`ifdef INTER_EDGE_TRIG_EN
    // One-cycle pulse on source 3: pending after 1 edge, request after 2.
    srcReq = 16'h0008;
    tick();
    srcReq = '0;
    check("e_pending3", {16'd0, pendingVec}, 32'h8);
    check("e_no_ask_yet", {31'd0, interAsk}, 32'd0);
    exp_q.push_back(8'd19);
    tick();
    check("e_latency2", {31'd0, interAsk}, 32'd1);
    askInterHandle = 1'b1;
    tick();
    check("e_accept_drop", {31'd0, interAsk}, 32'd0);
    check("e_accept_clear", {16'd0, pendingVec}, 32'd0);
    askInterHandle = 1'b0;
    tick();

    // Sources 5 and 2 together: 2 first, 5 after the handler returns.
    srcReq = 16'h0024;
    tick();
    srcReq = '0;
    exp_q.push_back(8'd18);
    exp_q.push_back(8'd21);
    wait_ask("e_ask18", 4);
    accept_round("e_h18", '0);
    check("e_gap_low", {31'd0, interAsk}, 32'd0);
    wait_ask("e_ask21", 4);

    // Source 0 arrives while 21 is outstanding: no re-arbitration.
    srcReq = 16'h0001;
    tick();
    srcReq = '0;
    tick();
    check("e_hold21", {24'd0, interCode}, 32'd21);
    exp_q.push_back(8'd16);
    accept_round("e_h21", '0);
    wait_ask("e_ask16", 4);
    accept_round("e_h16", '0);

    // Pending 4 and 7 flushed by a 4-cycle restart.
    srcReq = 16'h0090;
    tick();
    srcReq = '0;
    check("e_pending47", {16'd0, pendingVec}, 32'h90);
    askRestartHandle = 1'b1;
    tick();
    check("e_rs1_ask", {31'd0, interAsk}, 32'd0);
    check("e_rs1_pending", {16'd0, pendingVec}, 32'd0);
    check("e_rs1_ready", {31'd0, readyRestart}, 32'd0);
    tick();
    check("e_rs2_ready", {31'd0, readyRestart}, 32'd1);
    repeat (2) tick();
    check("e_rs4_ready", {31'd0, readyRestart}, 32'd1);
    askRestartHandle = 1'b0;
    tick();
    check("e_rs_ready_clr", {31'd0, readyRestart}, 32'd0);
    repeat (4) tick();
    check("e_rs_no_ask", {31'd0, interAsk}, 32'd0);
    check("e_rs_pending", {16'd0, pendingVec}, 32'd0);

    // New edge on source 3 in its own accept cycle: set beats clear.
    srcReq = 16'h0008;
    tick();
    srcReq = '0;
    exp_q.push_back(8'd19);
    exp_q.push_back(8'd19);
    wait_ask("e_ask19a", 4);
    askInterHandle = 1'b1;
    srcReq         = 16'h0008;
    tick();
    srcReq = '0;
    check("e_setwins_pending", {16'd0, pendingVec}, 32'h8);
    check("e_setwins_drop", {31'd0, interAsk}, 32'd0);
    askInterHandle = 1'b0;
    tick();
    wait_ask("e_ask19b", 4);
    accept_round("e_h19b", '0);
`else
    // Disabled source held high: visible as pending but never requested.
    srcEnable = 16'hFFFD;
    srcReq    = 16'h0002;
    repeat (4) tick();
    check("l_disabled_no_ask", {31'd0, interAsk}, 32'd0);
    check("l_pending_raw", {16'd0, pendingVec}, 32'h2);
    srcEnable = '1;
    exp_q.push_back(8'd17);
    tick();
    check("l_latency1", {31'd0, interAsk}, 32'd1);
    accept_round("l_h17", '0);

    // Sources 5 and 2 together; 2 drops during its handler, 5 stays high.
    srcReq = 16'h0024;
    exp_q.push_back(8'd18);
    exp_q.push_back(8'd21);
    wait_ask("l_ask18", 3);
    accept_round("l_h18", 16'h0020);
    check("l_gap_low", {31'd0, interAsk}, 32'd0);
    tick();
    check("l_ask21_next", {31'd0, interAsk}, 32'd1);

    // Source 0 arrives while 21 is outstanding: no re-arbitration.
    srcReq = 16'h0021;
    repeat (2) tick();
    check("l_hold21", {24'd0, interCode}, 32'd21);
    exp_q.push_back(8'd16);
    accept_round("l_h21", 16'h0001);
    wait_ask("l_ask16", 4);
    accept_round("l_h16", '0);

    // Restart blocks requests from 4 and 7 while asserted.
    srcReq           = 16'h0090;
    askRestartHandle = 1'b1;
    tick();
    check("l_rs1_ask", {31'd0, interAsk}, 32'd0);
    check("l_rs1_ready", {31'd0, readyRestart}, 32'd0);
    tick();
    check("l_rs2_ready", {31'd0, readyRestart}, 32'd1);
    repeat (2) tick();
    check("l_rs4_ask", {31'd0, interAsk}, 32'd0);
    askRestartHandle = 1'b0;
    srcReq           = '0;
    tick();
    check("l_rs_ready_clr", {31'd0, readyRestart}, 32'd0);
    repeat (3) tick();
    check("l_rs_no_ask", {31'd0, interAsk}, 32'd0);

    // Restart while a request is outstanding withdraws it.
    srcReq = 16'h0040;
    exp_q.push_back(8'd22);
    wait_ask("l_ask22", 3);
    askRestartHandle = 1'b1;
    srcReq           = '0;
    tick();
    check("l_rs_withdraw", {31'd0, interAsk}, 32'd0);
    askRestartHandle = 1'b0;
    repeat (3) tick();
    check("l_rs_after_idle", {31'd0, interAsk}, 32'd0);
    check("l_code_holds", {24'd0, interCode}, 32'd22);
`endif

    repeat (2) tick();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
